// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//
// Captures a signed 32-bit result, runs it through the external binary-to-BCD
// converter with a start/done handshake, and time-multiplexes the eight digits
// of the seven-segment display in a single clock domain.
//
// Build option: define DISPLAY_SCAN_BLANK_EN to insert BLANK_CYCLES of dead
// time (all digits off) at the start of every digit slot.
//
// Parameters:
//   TICK_DIV     clock cycles per digit slot (>= 2*BLANK_CYCLES)
//   BLANK_CYCLES dead-time cycles per slot (DISPLAY_SCAN_BLANK_EN only)
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   value        two's-complement result to display
//   update       one-cycle request to capture value
//   show_in_hex  1 = hex digits of the magnitude, 0 = decimal (live)
//   conv_bin     magnitude presented to the converter
//   conv_start   one-cycle converter start pulse
//   conv_done    one-cycle converter completion pulse
//   conv_bcd     8-digit BCD result, valid with conv_done
//   control      active-low digit enables, bit n = digit n (0 = rightmost)
//   digit_code   symbol for the active digit: 0-15, 18 = minus, 31 = empty
//   busy         conversion in flight or pending
//   overflow     captured value cannot be shown in the current mode

module display_scan_ctrl #(
  parameter int unsigned TICK_DIV     = 8192,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        update,
  input  logic        show_in_hex,
  output logic [31:0] conv_bin,
  output logic        conv_start,
  input  logic        conv_done,
  input  logic [31:0] conv_bcd,
  output logic [7:0]  control,
  output logic [4:0]  digit_code,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned CntW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [4:0]  CodeMinus = 5'd18;
  localparam logic [4:0]  CodeEmpty = 5'd31;
  localparam logic [31:0] DecMax    = 32'd99999999;

  if ((TICK_DIV < 2) || (TICK_DIV < 2 * BLANK_CYCLES)) begin : g_cfg_check
    $error("display_scan_ctrl: TICK_DIV must be >= 2 and >= 2*BLANK_CYCLES");
  end

  typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

  state_e      state_q, state_d;
  logic        pending_q;
  logic        sign_q, sign_n_q;
  logic [31:0] mag_q, mag_n_q;
  logic        ovf_dec_q, ovf_n_q;
  logic [31:0] bcd_q;
  logic [CntW-1:0] slot_cnt_q;
  logic [2:0]  digit_sel_q;

  // Decoded view of the value bus; -2^31 wraps to magnitude 0x80000000.
  logic        cap_sign;
  logic [31:0] cap_mag;
  logic        cap_ovf;

  always_comb begin
    cap_sign = value[31];
    cap_mag  = cap_sign ? (~value + 32'd1) : value;
    cap_ovf  = cap_mag > DecMax;
  end

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (update) state_d = StStart;
      StStart: state_d = StWait;
      // An update coinciding with done counts as pending so it is not lost.
      StWait:  if (conv_done) state_d = (pending_q || update) ? StStart : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    conv_start = (state_q == StStart);
    conv_bin   = mag_q;
    busy       = (state_q != StIdle) || pending_q;
  end

  // Capture, shadow and result registers. The live registers only change in
  // IDLE or on the WAIT->START transition, so conv_bin is stable while the
  // converter works.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= 1'b0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      ovf_dec_q <= 1'b0;
      sign_n_q  <= 1'b0;
      mag_n_q   <= '0;
      ovf_n_q   <= 1'b0;
      bcd_q     <= '0;
    end else begin
      if (state_q == StIdle) begin
        if (update) begin
          sign_q    <= cap_sign;
          mag_q     <= cap_mag;
          ovf_dec_q <= cap_ovf;
        end
      end else if (update) begin
        sign_n_q  <= cap_sign;
        mag_n_q   <= cap_mag;
        ovf_n_q   <= cap_ovf;
        pending_q <= 1'b1;
      end

      if ((state_q == StWait) && conv_done) begin
        bcd_q <= conv_bcd;
        if (pending_q || update) begin
          pending_q <= 1'b0;
          // Newest request wins: a same-cycle update bypasses the shadow.
          sign_q    <= update ? cap_sign : sign_n_q;
          mag_q     <= update ? cap_mag  : mag_n_q;
          ovf_dec_q <= update ? cap_ovf  : ovf_n_q;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit scan
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_cnt_q  <= '0;
      digit_sel_q <= '0;
    end else if (slot_cnt_q == CntW'(TICK_DIV - 1)) begin
      slot_cnt_q  <= '0;
      digit_sel_q <= digit_sel_q + 3'd1;
    end else begin
      slot_cnt_q  <= slot_cnt_q + 1'b1;
    end
  end

  always_comb begin
    control = ~(8'd1 << digit_sel_q);
`ifdef DISPLAY_SCAN_BLANK_EN
    if (slot_cnt_q < CntW'(BLANK_CYCLES)) begin
      control = 8'hFF;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Symbol selection
  // ---------------------------------------------------------------------------
  logic [31:0] word;
  logic [4:0]  shamt;
  logic [3:0]  nib;
  logic        upper_nz;

  always_comb begin
    word     = show_in_hex ? mag_q : bcd_q;
    // In hex the top digit is taken by the minus sign, so a negative value
    // needing all eight nibbles cannot be shown.
    overflow = show_in_hex ? (sign_q && (mag_q[31:28] != 4'd0)) : ovf_dec_q;
    shamt    = {digit_sel_q, 2'b00};
    nib      = word[shamt +: 4];
    // Nonzero at or above this digit: otherwise it is a leading zero.
    upper_nz = (word >> shamt) != 32'd0;

    if (overflow) begin
      digit_code = CodeMinus;
    end else if (digit_sel_q == 3'd0) begin
      digit_code = {1'b0, nib};
    end else if (digit_sel_q == 3'd7) begin
      if (sign_q) begin
        digit_code = CodeMinus;
      end else begin
        digit_code = (nib != 4'd0) ? {1'b0, nib} : CodeEmpty;
      end
    end else begin
      digit_code = upper_nz ? {1'b0, nib} : CodeEmpty;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: a vector table of captured values
// with hand-computed digit codes, plus directed sequences for reset during a
// conversion, back-to-back updates and live mode toggling.

module tb_display_scan_ctrl;

  localparam int unsigned TICK  = 16;
  localparam int unsigned BLANK = 4;
  localparam int unsigned LAT   = 40;
`ifdef DISPLAY_SCAN_BLANK_EN
  localparam bit BlankEn = 1'b1;
`else
  localparam bit BlankEn = 1'b0;
`endif

  localparam logic [4:0] M = 5'd18;
  localparam logic [4:0] E = 5'd31;

  logic        clock;
  logic        reset;
  logic [31:0] value;
  logic        update;
  logic        show_in_hex;
  logic [31:0] conv_bin;
  logic        conv_start;
  logic        conv_done;
  logic [31:0] conv_bcd;
  logic [7:0]  control;
  logic [4:0]  digit_code;
  logic        busy;
  logic        overflow;

  display_scan_ctrl #(
    .TICK_DIV    (TICK),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .value      (value),
    .update     (update),
    .show_in_hex(show_in_hex),
    .conv_bin   (conv_bin),
    .conv_start (conv_start),
    .conv_done  (conv_done),
    .conv_bcd   (conv_bcd),
    .control    (control),
    .digit_code (digit_code),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference scan position.
  int unsigned m_cnt;
  logic [2:0]  m_sel;
  always @(posedge clock) begin
    if (reset) begin
      m_cnt <= 0;
      m_sel <= 3'd0;
    end else if (m_cnt == TICK - 1) begin
      m_cnt <= 0;
      m_sel <= m_sel + 3'd1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // conv_start pulses seen (sampled at the edge ending the START cycle).
  int n_starts = 0;
  always @(posedge clock) begin
    if (conv_start === 1'b1) n_starts <= n_starts + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_ctrl(input int unsigned cnt, input logic [2:0] sel);
    if (BlankEn && (cnt < BLANK)) return 8'hFF;
    return ~(8'd1 << sel);
  endfunction

  // Converter model response.
  function automatic logic [31:0] to_bcd(input logic [31:0] b);
    logic [31:0] r;
    int unsigned v;
    r = '0;
    v = b % 100000000;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Watch one full scan: collect every digit's code and check control each cycle.
  task automatic scan_check(input string tag, input logic [39:0] exp_codes);
    logic [4:0]  seen [8];
    logic [39:0] got;
    int unsigned bad;
    bad = 0;
    got = '0;
    for (int k = 0; k < 8; k++) seen[k] = 5'd0;
    repeat (8 * TICK) begin
      @(negedge clock);
      seen[m_sel] = digit_code;
      if (control !== exp_ctrl(m_cnt, m_sel)) bad++;
    end
    for (int k = 0; k < 8; k++) got[5*k +: 5] = seen[k];
    check({tag, "_digits"}, got, exp_codes);
    check({tag, "_ctrl_errs"}, bad, 0);
  endtask

  task automatic do_update(input logic [31:0] v, input logic [31:0] exp_bin, input string tag);
    @(negedge clock);
    value  = v;
    update = 1'b1;
    @(negedge clock);
    update = 1'b0;
    check({tag, "_start"}, conv_start, 1'b1);
    check({tag, "_bin"}, conv_bin, exp_bin);
  endtask

  task automatic finish_conv(input string tag);
    repeat (LAT - 1) @(negedge clock);
    check({tag, "_busy_before_done"}, busy, 1'b1);
    conv_bcd  = to_bcd(conv_bin);
    conv_done = 1'b1;
    @(negedge clock);
    conv_done = 1'b0;
    check({tag, "_busy_after_done"}, busy, 1'b0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] val;
    logic        hex;
    logic [31:0] bin;
    logic [39:0] codes;  // {d7, ..., d0}
    logic        ovf;
  } vec_t;

  localparam int NV = 11;
  vec_t vec [NV];

  initial begin
    int          n0;
    logic [39:0] ec;

    vec[0]  = '{"dec_neg1234", 32'hFFFFFB2E, 1'b0, 32'd1234,
                {M, E, E, E, 5'd1, 5'd2, 5'd3, 5'd4}, 1'b0};
    vec[1]  = '{"dec_7", 32'd7, 1'b0, 32'd7, {E, E, E, E, E, E, E, 5'd7}, 1'b0};
    vec[2]  = '{"dec_max", 32'd99999999, 1'b0, 32'd99999999, {8{5'd9}}, 1'b0};
    vec[3]  = '{"dec_ovf", 32'd100000000, 1'b0, 32'd100000000, {8{M}}, 1'b1};
    vec[4]  = '{"dec_minint", 32'h80000000, 1'b0, 32'h80000000, {8{M}}, 1'b1};
    vec[5]  = '{"hex_minint", 32'h80000000, 1'b1, 32'h80000000, {8{M}}, 1'b1};
    vec[6]  = '{"hex_maxpos", 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, {5'd7, {7{5'd15}}}, 1'b0};
    vec[7]  = '{"hex_zero", 32'd0, 1'b1, 32'd0, {E, E, E, E, E, E, E, 5'd0}, 1'b0};
    vec[8]  = '{"hex_abc", 32'h00ABC000, 1'b1, 32'h00ABC000,
                {E, E, 5'd10, 5'd11, 5'd12, 5'd0, 5'd0, 5'd0}, 1'b0};
    vec[9]  = '{"hex_m16", 32'hFFFFFFF0, 1'b1, 32'h00000010,
                {M, E, E, E, E, E, 5'd1, 5'd0}, 1'b0};
    vec[10] = '{"hex_neg_ovf", 32'hF0000000, 1'b1, 32'h10000000, {8{M}}, 1'b1};

    reset       = 1'b1;
    value       = '0;
    update      = 1'b0;
    show_in_hex = 1'b0;
    conv_done   = 1'b0;
    conv_bcd    = '0;

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_conv_start", conv_start, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_digit_code", digit_code, 5'd0);
    check("rst_control", control, BlankEn ? 8'hFF : 8'hFE);
    reset = 1'b0;
    scan_check("rst_scan", {E, E, E, E, E, E, E, 5'd0});
    check("rst_busy_after_scan", busy, 1'b0);

    // Reset during WAIT; the late done must not load bcd_r.
    n0 = n_starts;
    do_update(32'hFFFFFFD6, 32'd42, "rstmid");
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset     = 1'b0;
    conv_bcd  = 32'h00000042;
    conv_done = 1'b1;
    @(negedge clock);
    conv_done = 1'b0;
    repeat (4) @(negedge clock);
    check("rstmid_starts", n_starts, n0 + 1);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_conv_start", conv_start, 1'b0);
    scan_check("rstmid_scan", {E, E, E, E, E, E, E, 5'd0});

    // Vector table.
    for (int i = 0; i < NV; i++) begin
      show_in_hex = vec[i].hex;
      n0 = n_starts;
      do_update(vec[i].val, vec[i].bin, vec[i].name);
      if (vec[i].hex) begin
        ec = vec[i].codes;
        check({vec[i].name, "_hex_latency"}, digit_code, ec[5*m_sel +: 5]);
      end
      finish_conv(vec[i].name);
      check({vec[i].name, "_nstarts"}, n_starts, n0 + 1);
      check({vec[i].name, "_overflow"}, overflow, vec[i].ovf);
      scan_check(vec[i].name, vec[i].codes);
    end

    // Live mode toggle: 99999999 = 0x05F5E0FF, no reconversion.
    show_in_hex = 1'b0;
    do_update(32'd99999999, 32'd99999999, "toggle");
    finish_conv("toggle");
    @(negedge clock);
    n0 = n_starts;
    show_in_hex = 1'b1;
    #1;
    ec = {E, 5'd5, 5'd15, 5'd5, 5'd14, 5'd0, 5'd15, 5'd15};
    check("toggle_to_hex_now", digit_code, ec[5*m_sel +: 5]);
    show_in_hex = 1'b0;
    #1;
    check("toggle_to_dec_now", digit_code, 5'd9);
    show_in_hex = 1'b1;
    scan_check("toggle_hex", {E, 5'd5, 5'd15, 5'd5, 5'd14, 5'd0, 5'd15, 5'd15});
    check("toggle_no_start", n_starts, n0);

    // Back-to-back updates; the last coincides with conv_done.
    show_in_hex = 1'b0;
    n0 = n_starts;
    do_update(32'd1, 32'd1, "b2b_first");
    @(negedge clock);
    repeat (5) @(negedge clock);
    value  = 32'd5;
    update = 1'b1;
    @(negedge clock);
    update = 1'b0;
    repeat (5) @(negedge clock);
    value  = 32'd6;
    update = 1'b1;
    @(negedge clock);
    update = 1'b0;
    check("b2b_bin_held", conv_bin, 32'd1);
    repeat (25) @(negedge clock);
    check("b2b_no_extra_start", n_starts, n0 + 1);
    check("b2b_busy_pending", busy, 1'b1);
    value     = 32'd7;
    update    = 1'b1;
    conv_bcd  = to_bcd(conv_bin);
    conv_done = 1'b1;
    @(negedge clock);
    update    = 1'b0;
    conv_done = 1'b0;
    check("b2b_restart", conv_start, 1'b1);
    check("b2b_restart_bin", conv_bin, 32'd7);
    finish_conv("b2b_second");
    check("b2b_nstarts", n_starts, n0 + 2);

    // conv_done while IDLE is ignored.
    conv_bcd  = 32'h00000055;
    conv_done = 1'b1;
    @(negedge clock);
    conv_done = 1'b0;
    @(negedge clock);
    check("idle_done_busy", busy, 1'b0);
    check("idle_done_nstarts", n_starts, n0 + 2);
    scan_check("b2b_scan", {E, E, E, E, E, E, E, 5'd7});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Sequencer for the 8-digit seven-segment display. It captures a signed 32-bit result on request and drives the external binary-to-BCD converter through a start/done handshake. It holds the converted and raw magnitudes and time-multiplexes the digits, emitting per-digit symbol codes for the downstream segment decoder. It sits between the calculator core and the segment decoder/pin driver, replacing free-running conversion and ripple-clocked scanning with a single clock domain.

## Interface
- `TICK_DIV`, 8192: clock cycles per digit slot; must be ≥ 2·`BLANK_CYCLES`.
- `BLANK_CYCLES`, 64: dead-time cycles at the start of each slot (only with the blanking macro, see Configuration).
- `clock` in 1: 50 MHz system clock.
- `reset` in 1: synchronous, active-high.
- `value` in 32: two's-complement result to display.
- `update` in 1: one-cycle request to capture `value`.
- `show_in_hex` in 1: 1 = hex digits of the magnitude, 0 = decimal; sampled live.
- `conv_bin` out 32: magnitude presented to the converter; held stable from `conv_start` until `conv_done`.
- `conv_start` out 1: one-cycle start pulse to the converter.
- `conv_done` in 1: one-cycle completion pulse from the converter.
- `conv_bcd` in 32: 8-digit BCD result, valid in the cycle `conv_done` is high.
- `control` out 8: active-low digit enables, bit n = digit n (digit 0 is rightmost).
- `digit_code` out 5: symbol for the active digit: 0–15 hex/decimal digit, 18 = minus, 31 = empty.
- `busy` out 1: a conversion is in flight or pending.
- `overflow` out 1: the captured value cannot be shown in the current mode.

## Operation
- Capture registers, all loaded on an accepted `update`:
  - `sign`: `value[31]`.
  - `mag`: `sign ? -value : value`, taken mod 2^32, so -2^31 gives 0x80000000.
  - `ovf_dec`: `mag > 99999999`.
- Conversion FSM states: IDLE, START, WAIT.
  - IDLE: on `update`, capture and go to START.
  - START: drive `conv_start` = 1 for exactly this cycle and drive `conv_bin` = `mag`; go to WAIT.
  - WAIT: on `conv_done`, load `bcd_r` from `conv_bcd`. Then go to START if `pending` = 1 (clearing `pending`), else go to IDLE.
- `update` in START or WAIT:
  - Capture into the shadow registers `mag_n`, `sign_n`, `ovf_n` and set `pending`.
  - The newest request wins; earlier pending requests are lost.
  - On the next START, the shadow registers are copied into the live capture registers.
- `conv_done` outside WAIT is ignored.
- `busy` = (state ≠ IDLE) | `pending`.
- Display word:
  - Hex mode: `mag`.
  - Decimal mode: `bcd_r`, the last completed conversion. Before any conversion completes after reset, `bcd_r` = 0.
- Overflow:
  - `overflow` = `show_in_hex ? (sign & mag[31:28] ≠ 0) : ovf_dec`.
  - When `overflow` = 1, every digit shows code 18 (minus).
- Digit code for slot n, when not in overflow:
  - n = 0: `word[3:0]`, so zero is always shown.
  - n = 1..6: `word[4n+3:4n]` if `word[31:4n]` ≠ 0, else 31 (leading-zero blanking).
  - n = 7: 18 if `sign`, else `word[31:28]` if nonzero, else 31.
- Scan:
  - `slot_cnt` counts 0..`TICK_DIV`-1.
  - At `TICK_DIV`-1, `slot_cnt` returns to 0 and `digit_sel` increments, wrapping 7 → 0.
  - `control` = ~(1 << `digit_sel`), except during blanking.

## Timing
- Reset values:
  - State IDLE, `pending` = 0, `sign` = 0, `mag` = 0, `bcd_r` = 0.
  - `slot_cnt` = 0, `digit_sel` = 0.
  - `conv_start` = 0, `busy` = 0, `overflow` = 0, `digit_code` = 0.
  - `control` = 8'hFF with the blanking macro, 8'hFE without.
- Reset mid-conversion: FSM returns to IDLE and `pending` clears. A late `conv_done` is ignored.
- Latency:
  - `conv_start` is high in the cycle after `update`.
  - `bcd_r` updates in the cycle after `conv_done`.
  - Hex display reflects `update` in the cycle after it.
- Simultaneous `update` and `conv_done` in WAIT: `bcd_r` loads, the shadow registers capture, and the FSM goes to START. No request is lost.
- `control` and `digit_code` are combinational from registered state and change on the same edge as `digit_sel`. Exactly one `control` bit is low outside blanking.
- `show_in_hex` toggles take effect in the same cycle; no reconversion is needed.

## Configuration
- Macro `DISPLAY_SCAN_BLANK_EN`.
- Defined: `control` = 8'hFF while `slot_cnt` < `BLANK_CYCLES` in every slot, suppressing ghosting at digit changes. `digit_code` is already valid for the new digit during blanking.
- Undefined: no dead time; a digit is enabled for the full slot. The `BLANK_CYCLES` parameter is unused.

## Test plan
- **Reset state:** reset, then run 8·`TICK_DIV` cycles. Required: `digit_code` = 0 in slot 0 and 31 in slots 1–7; `control` walks FE, FD, …, 7F and wraps to FE; `busy` = 0.
- **Decimal conversion:** `update` with `value` = -1234, converter model answers with `conv_bcd` = 0x00001234 after 40 cycles. Required: `conv_start` pulses once with `conv_bin` = 1234; digits 0–3 show 4, 3, 2, 1; digits 4–6 are empty; digit 7 shows 18.
- **Back-to-back updates:** three `update` pulses during WAIT with values 5, 6, 7, the last coinciding with `conv_done`. Required: exactly one further `conv_start`, with `conv_bin` = 7; `busy` drops only after its `conv_done`.
- **Overflow:** `value` = 100000000 in decimal mode → all digits 18 and `overflow` = 1. `value` = 0x80000000 in hex mode → `overflow` = 1. `value` = 0x7FFFFFFF in hex mode → digits F,F,F,F,F,F,F,7 and `overflow` = 0.
- **Reset mid-conversion:** assert `reset` in WAIT, then pulse `conv_done`. Required: `bcd_r` unchanged at 0, state IDLE, no `conv_start`.
- **Blanking (macro defined):** `control` = FF for exactly 64 cycles at each slot start, then a single low bit for 8128 cycles. With the macro undefined, `control` is never FF.
